// File: rtl/wrap_counter_pkg.sv
// Shared constants for the wrap/saturate counter bank: direction and boundary
// mode encodings plus the default parameter set.
package wrap_counter_pkg;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

    localparam int DEF_WIDTH    = 11;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_LIMIT    = 500;
    localparam int DEF_WRAP_VAL = 1;

endpackage : wrap_counter_pkg

// File: rtl/wrap_counter_chan.sv
// One counter channel: load/count with wrap or saturate at [WRAP_VAL, LIMIT],
// a registered wrap pulse, and a sticky out-of-range-load error flag.
module wrap_counter_chan
    import wrap_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LIMIT    = DEF_LIMIT,
    parameter int WRAP_VAL = DEF_WRAP_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             sat_mode,
    input  logic             err_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             err
);

    if (LIMIT < 0 || longint'(LIMIT) >= (longint'(1) << WIDTH)) begin : g_bad_limit
        $error("wrap_counter_chan: LIMIT must fit in WIDTH bits");
    end
    if (WRAP_VAL < 0 || WRAP_VAL > LIMIT) begin : g_bad_wrap_val
        $error("wrap_counter_chan: WRAP_VAL must lie in [0, LIMIT]");
    end

    localparam logic [WIDTH-1:0] LIM_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] WV_W  = WIDTH'(WRAP_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_next_cnt;
    logic             w_next_wrap;
    logic             w_next_err;
    logic             w_load_oor;

    always_comb begin
        w_next_cnt  = r_cnt;
        w_next_wrap = 1'b0;
        w_load_oor  = ld && (ld_val > LIM_W);

        if (ld) begin
            w_next_cnt = w_load_oor ? LIM_W : ld_val;
        end else if (en) begin
            if (dir == UP) begin
                // r_cnt < LIM_W keeps the increment from ever overflowing WIDTH bits
                if (r_cnt < LIM_W) begin
                    w_next_cnt = r_cnt + WIDTH'(1);
                end else if (sat_mode == WRAP) begin
                    w_next_cnt  = WV_W;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_cnt = LIM_W;
                end
            end else begin
                if (r_cnt > WV_W) begin
                    w_next_cnt = r_cnt - WIDTH'(1);
                end else if (sat_mode == WRAP) begin
                    w_next_cnt  = LIM_W;
                    w_next_wrap = 1'b1;
                end
            end
        end

        // A coincident out-of-range load wins over the clear.
        if (w_load_oor) begin
            w_next_err = 1'b1;
        end else if (err_clr) begin
            w_next_err = 1'b0;
        end else begin
            w_next_err = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cnt  <= w_next_cnt;
            r_wrap <= w_next_wrap;
            r_err  <= w_next_err;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule : wrap_counter_chan

// File: rtl/wrap_counter_bank.sv
// Bank of independent wrap/saturate counters; this level only slices the
// packed buses per channel and fans out the shared mode and error clear.
module wrap_counter_bank
    import wrap_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int LIMIT    = DEF_LIMIT,
    parameter int WRAP_VAL = DEF_WRAP_VAL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS*WIDTH-1:0] ld_val,
    input  logic                      sat_mode,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       err
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("wrap_counter_bank: CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        wrap_counter_chan #(
            .WIDTH    (WIDTH),
            .LIMIT    (LIMIT),
            .WRAP_VAL (WRAP_VAL)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .dir      (dir[i]),
            .ld       (ld[i]),
            .ld_val   (ld_val[i*WIDTH +: WIDTH]),
            .sat_mode (sat_mode),
            .err_clr  (err_clr),
            .cnt      (cnt[i*WIDTH +: WIDTH]),
            .wrap     (wrap[i]),
            .err      (err[i])
        );
    end

endmodule : wrap_counter_bank

// File: tb/tb_wrap_counter_bank.sv
// Scoreboarded bench for wrap_counter_bank: directed boundary scenarios followed
// by randomized traffic, all checked against a per-channel behavioural model.
module tb_wrap_counter_bank;

    localparam int WD  = 11;
    localparam int CH  = 4;
    localparam int LIM = 500;
    localparam int WV  = 1;
    localparam int W   = CH*WD + 2*CH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CH-1:0]    en = '0;
    logic [CH-1:0]    dir = '0;
    logic [CH-1:0]    ld = '0;
    logic [CH*WD-1:0] ld_val = '0;
    logic             sat_mode = 1'b0;
    logic             err_clr = 1'b0;
    logic [CH*WD-1:0] cnt;
    logic [CH-1:0]    wrap;
    logic [CH-1:0]    err;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    int m_cnt[CH];
    bit m_err[CH];

    wrap_counter_bank #(
        .WIDTH    (WD),
        .CHANNELS (CH),
        .LIMIT    (LIM),
        .WRAP_VAL (WV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .ld       (ld),
        .ld_val   (ld_val),
        .sat_mode (sat_mode),
        .err_clr  (err_clr),
        .cnt      (cnt),
        .wrap     (wrap),
        .err      (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [CH*WD-1:0] lv1(input int ch, input int val);
        logic [CH*WD-1:0] v;
        v = '0;
        v[ch*WD +: WD] = WD'(val);
        return v;
    endfunction

    function automatic int cnt_of(input int ch);
        return int'(cnt[ch*WD +: WD]);
    endfunction

    // Model of one clock edge, computed straight from the counting rules.
    task automatic drive(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] d,
                         input logic [CH-1:0] l, input logic [CH*WD-1:0] lv,
                         input logic s, input logic ec);
        logic [CH*WD-1:0] x_cnt;
        logic [CH-1:0]    x_wrap;
        logic [CH-1:0]    x_err;
        @(negedge clk);
        rst = r; en = e; dir = d; ld = l; ld_val = lv; sat_mode = s; err_clr = ec;
        x_wrap = '0;
        for (int i = 0; i < CH; i++) begin
            int v = int'(lv[i*WD +: WD]);
            if (r) begin
                m_cnt[i] = 0;
                m_err[i] = 1'b0;
            end else begin
                if (l[i]) begin
                    m_cnt[i] = (v > LIM) ? LIM : v;
                end else if (e[i] && !d[i]) begin
                    if (m_cnt[i] < LIM) m_cnt[i] = m_cnt[i] + 1;
                    else if (!s) begin m_cnt[i] = WV; x_wrap[i] = 1'b1; end
                end else if (e[i] && d[i]) begin
                    if (m_cnt[i] > WV) m_cnt[i] = m_cnt[i] - 1;
                    else if (!s) begin m_cnt[i] = LIM; x_wrap[i] = 1'b1; end
                end
                if (l[i] && v > LIM) m_err[i] = 1'b1;
                else if (ec)         m_err[i] = 1'b0;
            end
            x_cnt[i*WD +: WD] = WD'(m_cnt[i]);
            x_err[i] = m_err[i];
        end
        exp_q.push_back({x_cnt, x_wrap, x_err});
    endtask

    task automatic idle(input logic s);
        drive(1'b0, '0, '0, '0, '0, s, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                if ({cnt, wrap, err} !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard @%0t: actual cnt=%h wrap=%b err=%b required cnt=%h wrap=%b err=%b",
                             $time, cnt, wrap, err, mon_exp[W-1 -: CH*WD],
                             mon_exp[2*CH-1 -: CH], mon_exp[CH-1:0]);
                end
                for (int i = 0; i < CH; i++) begin
                    checks++;
                    if (cnt[i*WD +: WD] > WD'(LIM)) begin
                        failures++;
                        $display("FAIL cnt_le_limit ch%0d: actual=%0d required<=%0d",
                                 i, cnt[i*WD +: WD], LIM);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wraps;
        logic s_rand;
        logic [CH*WD-1:0] lv_rand;
        logic [CH-1:0] l_rand;

        // Reset state
        drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        sample();
        check("reset_cnt", cnt, 0);
        check("reset_wrap", wrap, 0);
        check("reset_err", err, 0);

        // Up count on ch0 across the LIMIT wrap
        wraps = 0;
        for (int k = 1; k <= 501; k++) begin
            drive(1'b0, 4'b0001, '0, '0, '0, 1'b0, 1'b0);
            sample();
            if (k == 500) check("ch0_reach_limit", cnt_of(0), 500);
            wraps += int'(wrap[0]);
        end
        check("ch0_wrap_count", wraps, 1);
        check("ch0_after_wrap", cnt_of(0), 1);
        check("ch0_wrap_with_1", wrap[0], 1);
        idle(1'b0);
        sample();
        check("ch0_wrap_one_cycle", wrap[0], 0);

        // Saturation at LIMIT on ch1
        drive(1'b0, '0, '0, 4'b0010, lv1(1, 500), 1'b0, 1'b0);
        sample();
        check("ch1_load_500", cnt_of(1), 500);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0010, '0, '0, '0, 1'b1, 1'b0);
            sample();
            check("ch1_sat_hold", cnt_of(1), 500);
            check("ch1_sat_nowrap", wrap[1], 0);
        end

        // Down wrap from 0 on ch2
        drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, 4'b0100, 4'b0100, '0, '0, 1'b0, 1'b0);
        sample();
        check("ch2_down_wrap_cnt", cnt_of(2), 500);
        check("ch2_down_wrap_pulse", wrap[2], 1);
        drive(1'b0, 4'b0100, 4'b0100, '0, '0, 1'b0, 1'b0);
        sample();
        check("ch2_down_dec", cnt_of(2), 499);
        check("ch2_down_pulse_end", wrap[2], 0);

        // Out-of-range load on ch3, sticky err, clear, and clear-vs-load collision
        drive(1'b0, 4'b1000, '0, 4'b1000, lv1(3, 2000), 1'b0, 1'b0);
        sample();
        check("ch3_oor_clamp", cnt_of(3), 500);
        check("ch3_oor_err", err[3], 1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            sample();
            check("ch3_err_sticky", err[3], 1);
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        sample();
        check("ch3_err_cleared", err[3], 0);
        drive(1'b0, '0, '0, 4'b1000, lv1(3, 1500), 1'b0, 1'b1);
        sample();
        check("ch3_err_clr_collide", err[3], 1);

        // Reset mid-count overrides load and enable
        drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 4'b1000, lv1(3, 2000), 1'b0, 1'b0);
        for (int k = 0; k < 250; k++) drive(1'b0, 4'b0111, '0, '0, '0, 1'b0, 1'b0);
        sample();
        check("mid_cnt0_250", cnt_of(0), 250);
        check("mid_cnt2_250", cnt_of(2), 250);
        check("mid_err3_set", err[3], 1);
        drive(1'b1, 4'b1111, '0, 4'b1111, {4{11'd2000}}, 1'b0, 1'b0);
        sample();
        check("rst_override_cnt", cnt, 0);
        check("rst_override_wrap", wrap, 0);
        check("rst_override_err", err, 0);
        drive(1'b0, 4'b1111, '0, '0, '0, 1'b0, 1'b0);
        sample();
        check("resume_after_rst", cnt_of(1), 1);

        // Randomized traffic
        s_rand = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if (k % 64 == 0) s_rand = 1'($urandom_range(1));
            l_rand = '0;
            for (int i = 0; i < CH; i++) begin
                int pick;
                l_rand[i] = ($urandom_range(7) == 0);
                pick = int'($urandom_range(7));
                case (pick)
                    0: lv_rand[i*WD +: WD] = 11'd0;
                    1: lv_rand[i*WD +: WD] = 11'd1;
                    2: lv_rand[i*WD +: WD] = 11'd499;
                    3: lv_rand[i*WD +: WD] = 11'd500;
                    4: lv_rand[i*WD +: WD] = 11'd501;
                    5: lv_rand[i*WD +: WD] = 11'd2047;
                    default: lv_rand[i*WD +: WD] = WD'($urandom);
                endcase
            end
            drive(($urandom_range(199) == 0), CH'($urandom), CH'($urandom), l_rand, lv_rand,
                  s_rand, ($urandom_range(15) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wrap_counter_bank
